// File: rtl/kyber_pkg.sv
// Shared constants and types for the Kyber polynomial decompress stream:
// modulus, polynomial size, legal compression widths and the framing FSM states.
package kyber_pkg;

   localparam int Q      = 3329;
   localparam int N      = 256;
   localparam int COEF_W = 12;
   localparam int IN_W   = 8;
   localparam int MAX_D  = 11;
   localparam int BUF_W  = IN_W + MAX_D - 1;
   localparam int PROD_W = 24;

   // Bit k set means d=k is supported: {1,4,5,10,11}.
   localparam logic [15:0] LEGAL_D_MASK = 16'h0C32;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   function automatic logic d_legal(input logic [3:0] d);
      return LEGAL_D_MASK[d];
   endfunction

endpackage

// File: rtl/poly_decompress_stream_if.sv
// Byte-in / coefficient-out stream bundle for the polynomial decompressor.
// The slave side is the decompressor, the master side is its environment.
interface poly_decompress_stream_if;
   import kyber_pkg::*;

   logic [IN_W-1:0]   in_data_i;
   logic              in_valid_i;
   logic              in_ready_o;
   logic [COEF_W-1:0] coef_o;
   logic              coef_valid_o;
   logic              coef_ready_i;
   logic              coef_last_o;

   modport master (
      output in_data_i, in_valid_i, coef_ready_i,
      input  in_ready_o, coef_o, coef_valid_o, coef_last_o
   );

   modport slave (
      input  in_data_i, in_valid_i, coef_ready_i,
      output in_ready_o, coef_o, coef_valid_o, coef_last_o
   );

endinterface

// File: rtl/decompress_core.sv
// Combinational Kyber decompress: coef = (Q*x + 2^(d-1)) >> d for a run-time d.
// Inputs above the selected d must already be masked to zero by the caller.
module decompress_core
   import kyber_pkg::*;
(
   input  logic [MAX_D-1:0]  x_i,
   input  logic [3:0]        d_i,
   output logic [COEF_W-1:0] coef_o
);

   logic [PROD_W-1:0] half;
   logic [PROD_W-1:0] prod;
   logic [PROD_W-1:0] rounded;

   always_comb begin
      half    = PROD_W'(1) << (d_i - 4'd1);
      prod    = PROD_W'(Q) * PROD_W'(x_i) + half;
      rounded = prod >> d_i;
   end

   // The quotient is always below Q, so the upper bits are structurally zero.
   assign coef_o = rounded[COEF_W-1:0];

   logic unused_hi;
   assign unused_hi = ^rounded[PROD_W-1:COEF_W];

endmodule

// File: rtl/poly_decompress_stream.sv
// Streaming Kyber ByteDecode + Decompress: unpacks LSB-first d-bit fields from a
// byte stream and emits N decompressed coefficients with valid/ready framing.
module poly_decompress_stream
   import kyber_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start_i,
   input  logic [3:0]                d_i,
   output logic                      busy_o,
   output logic                      mode_err_o,
   poly_decompress_stream_if.slave   s_if
);

   state_e            state_q, state_d;
   logic [3:0]        d_q, d_d;
   logic [BUF_W-1:0]  buf_q, buf_d;
   logic [4:0]        bitcnt_q, bitcnt_d;
   logic [8:0]        bytes_left_q, bytes_left_d;
   logic [7:0]        coef_cnt_q, coef_cnt_d;
   logic [COEF_W-1:0] coef_q, coef_d;
   logic              coef_valid_q, coef_valid_d;
   logic              coef_last_q, coef_last_d;
   logic              mode_err_q, mode_err_d;

   logic              in_ready;
   logic              accept;
   logic              extract;
   logic              out_free;
   logic [4:0]        d_ext;
   logic [MAX_D-1:0]  x_mask;
   logic [MAX_D-1:0]  x_val;
   logic [COEF_W-1:0] core_coef;

   assign d_ext    = {1'b0, d_q};
   assign out_free = !coef_valid_q || s_if.coef_ready_i;
   assign x_mask   = MAX_D'((12'd1 << d_q) - 12'd1);
   assign x_val    = buf_q[MAX_D-1:0] & x_mask;

   decompress_core u_core (
      .x_i    (x_val),
      .d_i    (d_q),
      .coef_o (core_coef)
   );

   always_comb begin
      state_d      = state_q;
      d_d          = d_q;
      buf_d        = buf_q;
      bitcnt_d     = bitcnt_q;
      bytes_left_d = bytes_left_q;
      coef_cnt_d   = coef_cnt_q;
      coef_d       = coef_q;
      coef_valid_d = coef_valid_q;
      coef_last_d  = coef_last_q;
      mode_err_d   = 1'b0;
      in_ready     = 1'b0;
      accept       = 1'b0;
      extract      = 1'b0;

      // Drain first; an extract below may refill the register in the same cycle.
      if (coef_valid_q && s_if.coef_ready_i) begin
         coef_valid_d = 1'b0;
         coef_last_d  = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               if (d_legal(d_i)) begin
                  state_d      = RUN;
                  d_d          = d_i;
                  bytes_left_d = {d_i, 5'd0};
                  buf_d        = '0;
                  bitcnt_d     = '0;
                  coef_cnt_d   = '0;
               end else begin
                  mode_err_d   = 1'b1;
               end
            end
         end
         RUN: begin
            in_ready = (bitcnt_q < d_ext) && (bytes_left_q != 9'd0);
            accept   = in_ready && s_if.in_valid_i;
            extract  = (bitcnt_q >= d_ext) && out_free;
            if (accept) begin
               buf_d        = buf_q | (BUF_W'(s_if.in_data_i) << bitcnt_q);
               bitcnt_d     = bitcnt_q + 5'd8;
               bytes_left_d = bytes_left_q - 9'd1;
            end
            if (extract) begin
               buf_d        = buf_q >> d_q;
               bitcnt_d     = bitcnt_q - d_ext;
               coef_d       = core_coef;
               coef_valid_d = 1'b1;
               coef_last_d  = (coef_cnt_q == 8'(N - 1));
               coef_cnt_d   = coef_cnt_q + 8'd1;
               if (coef_cnt_q == 8'(N - 1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (coef_valid_q && s_if.coef_ready_i && coef_last_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         d_q          <= '0;
         buf_q        <= '0;
         bitcnt_q     <= '0;
         bytes_left_q <= '0;
         coef_cnt_q   <= '0;
         coef_q       <= '0;
         coef_valid_q <= 1'b0;
         coef_last_q  <= 1'b0;
         mode_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         d_q          <= d_d;
         buf_q        <= buf_d;
         bitcnt_q     <= bitcnt_d;
         bytes_left_q <= bytes_left_d;
         coef_cnt_q   <= coef_cnt_d;
         coef_q       <= coef_d;
         coef_valid_q <= coef_valid_d;
         coef_last_q  <= coef_last_d;
         mode_err_q   <= mode_err_d;
      end
   end

   assign busy_o            = (state_q != IDLE);
   assign mode_err_o        = mode_err_q;
   assign s_if.in_ready_o   = in_ready;
   assign s_if.coef_o       = coef_q;
   assign s_if.coef_valid_o = coef_valid_q;
   assign s_if.coef_last_o  = coef_last_q;

   // N*d is a whole number of bytes, so the final extract must drain everything.
   a_framing: assert property (@(posedge clk) disable iff (!rst_n)
      (extract && coef_cnt_q == 8'(N - 1)) |-> (bitcnt_q == d_ext && bytes_left_q == 9'd0));

endmodule

// File: tb/tb_poly_decompress_stream.sv
// Randomised bench for poly_decompress_stream against a bit-stream reference model.
module tb_poly_decompress_stream;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_i = 1'b0;
   logic [3:0] d_i = 4'd0;
   logic       busy_o;
   logic       mode_err_o;

   poly_decompress_stream_if pif ();

   poly_decompress_stream dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start_i),
      .d_i        (d_i),
      .busy_o     (busy_o),
      .mode_err_o (mode_err_o),
      .s_if       (pif)
   );

   always #5 clk = ~clk;

   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] bytes_mem [0:351];
   int         got_coef [$];
   bit         got_last [$];
   int         bad_idx, bad_got, bad_exp;

   int  n_bytes, n_stall_err, n_err_pulse, n_busy_drop;
   bit  timed_out;

   // Coefficient idx = field [idx*d +: d] of the LSB-first bit stream, then rounded Q*x/2^d.
   function automatic int model_coef(int d, int idx);
      int x = 0;
      for (int b = 0; b < d; b++) begin
         int pos = idx * d + b;
         int bv  = int'(bytes_mem[pos / 8]);
         x += ((bv >> (pos % 8)) & 1) * (2 ** b);
      end
      return (3329 * x + 2 ** (d - 1)) / (2 ** d);
   endfunction

   function automatic int count_diffs(int d);
      int diffs = 0;
      bad_idx = -1; bad_got = 0; bad_exp = 0;
      for (int i = 0; i < got_coef.size(); i++) begin
         int exp_c = model_coef(d, i);
         if (got_coef[i] != exp_c || got_last[i] != (i == 255)) begin
            if (diffs == 0) begin
               bad_idx = i; bad_got = got_coef[i]; bad_exp = exp_c;
            end
            diffs++;
         end
      end
      return diffs;
   endfunction

   task automatic fill_random();
      for (int i = 0; i < 352; i++) bytes_mem[i] = 8'($urandom);
   endtask

   task automatic fill_const(input logic [7:0] v);
      for (int i = 0; i < 352; i++) bytes_mem[i] = v;
   endtask

   // Starts a polynomial and streams until stop_at coefficients have handshaked.
   task automatic run_stream(input int d, input int rdy_pct, input int vld_pct,
                             input int stop_at, input int poke_at);
      bit          stall = 1'b0;
      bit          poked = 1'b0;
      logic [11:0] held = '0;
      logic        held_last = 1'b0;
      got_coef.delete(); got_last.delete();
      n_bytes = 0; n_stall_err = 0; n_err_pulse = 0; n_busy_drop = 0;
      timed_out = 1'b1;
      @(negedge clk);
      start_i = 1'b1; d_i = 4'(d);
      @(negedge clk);
      for (int cyc = 0; cyc < 20000; cyc++) begin
         start_i = 1'b0;
         if (poke_at >= 0 && !poked && got_coef.size() == poke_at) begin
            start_i = 1'b1; d_i = 4'd10; poked = 1'b1;
         end
         pif.in_valid_i   = ($urandom_range(99) < vld_pct) && (n_bytes < 32 * d);
         pif.in_data_i    = pif.in_valid_i ? bytes_mem[n_bytes] : 8'($urandom);
         pif.coef_ready_i = ($urandom_range(99) < rdy_pct);
         #1;
         if (mode_err_o) n_err_pulse++;
         if (!busy_o) n_busy_drop++;
         if (stall && !(pif.coef_valid_o && pif.coef_o === held && pif.coef_last_o === held_last))
            n_stall_err++;
         if (pif.in_valid_i && pif.in_ready_o) n_bytes++;
         if (pif.coef_valid_o && pif.coef_ready_i) begin
            got_coef.push_back(int'(pif.coef_o));
            got_last.push_back(pif.coef_last_o);
         end
         stall     = pif.coef_valid_o && !pif.coef_ready_i;
         held      = pif.coef_o;
         held_last = pif.coef_last_o;
         if (got_coef.size() >= stop_at) begin
            timed_out = 1'b0;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic quiesce();
      @(negedge clk);
      start_i = 1'b0;
      pif.in_valid_i = 1'b0;
      pif.coef_ready_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1;
      vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b required 0", busy_o); end
      vectors++; if (mode_err_o !== 1'b0) begin miscompares++; $display("FAIL reset_mode_err: got %b required 0", mode_err_o); end
      vectors++; if (pif.in_ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b required 0", pif.in_ready_o); end
      vectors++; if (pif.coef_o !== 12'd0) begin miscompares++; $display("FAIL reset_coef: got %0d required 0", pif.coef_o); end
      vectors++; if (pif.coef_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_coef_valid: got %b required 0", pif.coef_valid_o); end
      vectors++; if (pif.coef_last_o !== 1'b0) begin miscompares++; $display("FAIL reset_coef_last: got %b required 0", pif.coef_last_o); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b required 0", busy_o); end
   endtask

   task automatic test_d11();
      int diffs;
      fill_random();
      bytes_mem[0] = 8'h04;                                   // x0 = 1028 = 0x404
      bytes_mem[1] = (bytes_mem[1] & 8'hF8) | 8'h04;
      run_stream(11, 100, 100, 256, -1);
      vectors++; if (timed_out !== 1'b0) begin miscompares++; $display("FAIL d11_timeout: got %0d coefs required 256", got_coef.size()); end
      vectors++; if (got_coef.size() > 0 && got_coef[0] != 1671) begin miscompares++; $display("FAIL d11_coef0: got %0d required 1671", got_coef[0]); end
      vectors++; if (n_bytes != 352) begin miscompares++; $display("FAIL d11_bytes: got %0d required 352", n_bytes); end
      diffs = count_diffs(11);
      vectors++; if (diffs != 0) begin miscompares++; $display("FAIL d11_stream: got %0d diffs (idx %0d got %0d want %0d) required 0", diffs, bad_idx, bad_got, bad_exp); end
      vectors++; if (n_busy_drop != 0) begin miscompares++; $display("FAIL d11_busy: got %0d low cycles required 0", n_busy_drop); end
      quiesce();
      #1;
      vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL d11_busy_end: got %b required 0", busy_o); end
   endtask

   task automatic test_d4();
      int diffs;
      fill_random();
      bytes_mem[0] = 8'hF1;
      run_stream(4, 100, 100, 256, -1);
      vectors++; if (got_coef.size() < 2 || got_coef[0] != 208) begin miscompares++; $display("FAIL d4_coef0: got %0d required 208", got_coef.size() > 0 ? got_coef[0] : -1); end
      vectors++; if (got_coef.size() < 2 || got_coef[1] != 3121) begin miscompares++; $display("FAIL d4_coef1: got %0d required 3121", got_coef.size() > 1 ? got_coef[1] : -1); end
      vectors++; if (n_bytes != 128) begin miscompares++; $display("FAIL d4_bytes: got %0d required 128", n_bytes); end
      diffs = count_diffs(4);
      vectors++; if (diffs != 0 || got_coef.size() != 256) begin miscompares++; $display("FAIL d4_stream: got %0d diffs, %0d coefs required 0, 256", diffs, got_coef.size()); end
      quiesce();
   endtask

   task automatic test_d1();
      int diffs = 0;
      fill_const(8'hAA);
      run_stream(1, 100, 100, 256, -1);
      for (int i = 0; i < got_coef.size(); i++)
         if (got_coef[i] != ((i % 2 == 1) ? 1665 : 0) || got_last[i] != (i == 255)) diffs++;
      vectors++; if (diffs != 0 || got_coef.size() != 256) begin miscompares++; $display("FAIL d1_alternate: got %0d diffs, %0d coefs required 0, 256", diffs, got_coef.size()); end
      vectors++; if (n_bytes != 32) begin miscompares++; $display("FAIL d1_bytes: got %0d required 32", n_bytes); end
      quiesce();
   endtask

   task automatic test_edge_values();
      int diffs = 0;
      fill_const(8'hFF);
      run_stream(10, 100, 100, 256, -1);
      for (int i = 0; i < got_coef.size(); i++) if (got_coef[i] != 3326) diffs++;
      vectors++; if (diffs != 0 || got_coef.size() != 256) begin miscompares++; $display("FAIL d10_max: got %0d diffs, %0d coefs required 0, 256", diffs, got_coef.size()); end
      quiesce();
      diffs = 0;
      fill_const(8'h00);
      run_stream(5, 100, 100, 256, -1);
      for (int i = 0; i < got_coef.size(); i++) if (got_coef[i] != 0) diffs++;
      vectors++; if (diffs != 0 || got_coef.size() != 256) begin miscompares++; $display("FAIL d5_zero: got %0d diffs, %0d coefs required 0, 256", diffs, got_coef.size()); end
      vectors++; if (n_bytes != 160) begin miscompares++; $display("FAIL d5_bytes: got %0d required 160", n_bytes); end
      quiesce();
   endtask

   task automatic test_random_d10();
      int diffs;
      fill_random();
      run_stream(10, 30, 60, 256, -1);
      diffs = count_diffs(10);
      vectors++; if (diffs != 0 || got_coef.size() != 256) begin miscompares++; $display("FAIL rand_d10_stream: got %0d diffs (idx %0d got %0d want %0d), %0d coefs required 0", diffs, bad_idx, bad_got, bad_exp, got_coef.size()); end
      vectors++; if (n_stall_err != 0) begin miscompares++; $display("FAIL rand_d10_stable: got %0d unstable stalls required 0", n_stall_err); end
      vectors++; if (n_bytes != 320) begin miscompares++; $display("FAIL rand_d10_bytes: got %0d required 320", n_bytes); end
      quiesce();
   endtask

   task automatic test_mode_err();
      @(negedge clk);
      start_i = 1'b1; d_i = 4'd3; pif.in_valid_i = 1'b1;
      #1;
      vectors++; if (mode_err_o !== 1'b0) begin miscompares++; $display("FAIL moderr_early: got %b required 0", mode_err_o); end
      @(negedge clk);
      start_i = 1'b0;
      #1;
      vectors++; if (mode_err_o !== 1'b1) begin miscompares++; $display("FAIL moderr_pulse: got %b required 1", mode_err_o); end
      vectors++; if (busy_o !== 1'b0 || pif.in_ready_o !== 1'b0) begin miscompares++; $display("FAIL moderr_idle: got busy %b ready %b required 0 0", busy_o, pif.in_ready_o); end
      @(negedge clk);
      #1;
      vectors++; if (mode_err_o !== 1'b0 || busy_o !== 1'b0) begin miscompares++; $display("FAIL moderr_once: got err %b busy %b required 0 0", mode_err_o, busy_o); end
      pif.in_valid_i = 1'b0;
   endtask

   task automatic test_start_mid_run();
      int diffs;
      fill_random();
      run_stream(4, 70, 80, 256, 50);
      diffs = count_diffs(4);
      vectors++; if (diffs != 0 || got_coef.size() != 256) begin miscompares++; $display("FAIL midrun_stream: got %0d diffs, %0d coefs required 0, 256", diffs, got_coef.size()); end
      vectors++; if (n_err_pulse != 0) begin miscompares++; $display("FAIL midrun_err: got %0d pulses required 0", n_err_pulse); end
      vectors++; if (n_bytes != 128) begin miscompares++; $display("FAIL midrun_bytes: got %0d required 128", n_bytes); end
      quiesce();
   endtask

   task automatic test_reset_mid_poly();
      int diffs;
      fill_random();
      run_stream(5, 100, 100, 100, -1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      vectors++; if ({busy_o, mode_err_o, pif.in_ready_o, pif.coef_valid_o, pif.coef_last_o} !== 5'b0) begin miscompares++; $display("FAIL async_rst_flags: got %b required 00000", {busy_o, mode_err_o, pif.in_ready_o, pif.coef_valid_o, pif.coef_last_o}); end
      vectors++; if (pif.coef_o !== 12'd0) begin miscompares++; $display("FAIL async_rst_coef: got %0d required 0", pif.coef_o); end
      quiesce();
      rst_n = 1'b1;
      fill_random();
      run_stream(5, 50, 70, 256, -1);
      diffs = count_diffs(5);
      vectors++; if (diffs != 0 || got_coef.size() != 256) begin miscompares++; $display("FAIL post_rst_stream: got %0d diffs, %0d coefs required 0, 256", diffs, got_coef.size()); end
      vectors++; if (n_bytes != 160) begin miscompares++; $display("FAIL post_rst_bytes: got %0d required 160", n_bytes); end
      quiesce();
   endtask

   initial begin
      pif.in_data_i    = 8'd0;
      pif.in_valid_i   = 1'b0;
      pif.coef_ready_i = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      test_d11();
      test_d4();
      test_d1();
      test_edge_values();
      test_random_d10();
      test_mode_err();
      test_start_mid_run();
      test_reset_mid_poly();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
